pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register for the rv32i pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces hand-written per-stage load/flush registers with a valid/ready handshake and a 2-entry skid buffer, so back-pressure need not ripple combinationally upstream.
- Supports synchronous flush with a configurable bubble payload (NOP control word, commit=0).
- Exposes occupancy and a saturating stall counter for performance monitoring.

Parameters:
- PAYLOAD_W, 256, width of packed stage payload (control word, operands, immediates, monitor fields).
- BUBBLE_VAL, '0 (PAYLOAD_W bits), payload driven on reset, on flush and whenever out_valid=0.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  PAYLOAD_W  upstream payload
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts this cycle
- out_data  out  PAYLOAD_W  main entry payload
- occupancy  out  2  held entries, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Storage: main register (drives out_data) plus skid register. State is EMPTY, ONE or TWO; occupancy = 0, 1 or 2 respectively.
- Handshake signals:
  - in_ready = (state != TWO); registered-state only, no combinational path from out_ready.
  - in_fire = in_valid & in_ready & ~flush.
  - out_fire = out_valid & out_ready.
  - out_valid = (state != EMPTY) & ~flush.
  - out_data = main when out_valid=1, otherwise BUBBLE_VAL.
- Transitions (rst, then flush, take priority):
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire only -> TWO, skid<=in_data.
    - out_fire only -> EMPTY, main<=BUBBLE_VAL.
    - neither -> hold.
  - TWO: in_fire impossible.
    - out_fire -> ONE, main<=skid, skid<=BUBBLE_VAL.
    - else hold.
- Ordering: strict FIFO. Skid is never bypassed; the oldest beat is always in main.
- Latency: 1 cycle in_fire -> out_valid when empty. Throughput 1 beat/cycle with out_ready held high.
- Flush:
  - Next state EMPTY; main and skid <= BUBBLE_VAL.
  - In the flush cycle the upstream beat is dropped even if in_ready=1, and no out_fire occurs (out_valid gated).
  - in_ready=1 from the cycle after flush.
- Reset: state EMPTY, main=skid=BUBBLE_VAL, stall_cnt=0. Resulting outputs: out_valid=0, in_ready=1, occupancy=0.
- Reset mid-operation aborts all held entries identically to flush, and also clears stall_cnt.
- stall_cnt:
  - +1 per cycle with out_valid & ~out_ready; saturates at all-ones.
  - stall_clr has priority over increment.
  - Not affected by flush.
- Simultaneous rst & flush behaves as rst.
- Payload registers are not written when state does not change and no fire occurs (hold, no spurious toggles).

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_occ_t {PIPE_EMPTY=0, PIPE_ONE=1, PIPE_TWO=2}.
  - Stage payload structs, e.g. id_ex_payload_t, bundling rv32i_control_word, packed_imm, operands and monitor_t.
  - Per-stage bubble constants, e.g. ID_EX_BUBBLE: op_imm/alu_add, load_regfile=0, commit=0.
- One sub-module: sat_counter (CNT_W, inc, clr, count), reusable for other perf counters.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_data=BUBBLE_VAL, stall_cnt=0.
- Streaming: out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> same values on out_data one cycle later each, occupancy stays 1, in_ready never drops.
- Back-pressure: out_ready=0, send 0xA1,0xA2,0xA3 -> occupancy 1 then 2, in_ready=0 after second beat, 0xA3 held upstream. Release out_ready -> output order 0xA1,0xA2,0xA3, stall_cnt equals stalled cycles.
- Flush while full: occupancy=2 with 0xB1,0xB2, flush=1 together with in_valid=1 and data 0xB3 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, 0xB3 never appears.
- Counter saturation: CNT_W=4, hold out_valid=1 & out_ready=0 for 20 cycles -> stall_cnt=15. stall_clr with increment in same cycle -> stall_cnt=0.
- Reset mid-stream: occupancy=2, assert rst -> next cycle state EMPTY, stall_cnt=0. Subsequent beat 0xC1 -> out_data=0xC1 after 1 cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy encoding, rv32i stage payloads and bubble constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_occ_t;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] aluop;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
    } rv32i_control_word;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [4:0]      shamt;
    } packed_imm;

    typedef struct packed {
        logic            commit;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } monitor_t;

    typedef struct packed {
        rv32i_control_word ctrl;
        packed_imm         imm;
        logic [XLEN-1:0]   rs1_v;
        logic [XLEN-1:0]   rs2_v;
        monitor_t          mon;
    } id_ex_payload_t;

    localparam int unsigned ID_EX_W = $bits(id_ex_payload_t);

    // ID/EX bubble: addi x0,x0,0 style NOP that never writes back or commits.
    function automatic id_ex_payload_t id_ex_bubble();
        id_ex_payload_t p;
        p              = '0;
        p.ctrl.opcode  = OP_IMM;
        p.ctrl.aluop   = ALU_ADD;
        return p;
    endfunction

    localparam id_ex_payload_t ID_EX_BUBBLE = id_ex_bubble();

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Count up on inc, stick at all-ones, clear has priority.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and 2-entry skid buffer.
// in_ready depends only on registered state, so back-pressure never ripples
// combinationally upstream. Oldest beat always sits in main.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W  = 256,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    input  logic                 stall_clr
);

    pipe_occ_t              state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   main_we, skid_we;
    logic                   in_fire, out_fire;

    // Handshake decode from registered state; flush gates both directions.
    always_comb begin
        in_ready  = (state_q != PIPE_TWO);
        out_valid = (state_q != PIPE_EMPTY) && !flush;
        in_fire   = in_valid && in_ready && !flush;
        out_fire  = out_valid && out_ready;
        out_data  = out_valid ? main_q : BUBBLE_VAL;
        occupancy = 2'(state_q);
    end

    // Next-state and payload write-enable logic; payload only written on a change.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        main_we = 1'b0;
        skid_we = 1'b0;
        if (flush) begin
            state_d = PIPE_EMPTY;
            main_we = 1'b1;
            main_d  = BUBBLE_VAL;
            skid_we = 1'b1;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (in_fire) begin
                        state_d = PIPE_ONE;
                        main_we = 1'b1;
                        main_d  = in_data;
                    end
                end
                PIPE_ONE: begin
                    if (in_fire && out_fire) begin
                        main_we = 1'b1;
                        main_d  = in_data;
                    end else if (in_fire) begin
                        state_d = PIPE_TWO;
                        skid_we = 1'b1;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = PIPE_EMPTY;
                        main_we = 1'b1;
                        main_d  = BUBBLE_VAL;
                    end
                end
                PIPE_TWO: begin
                    if (out_fire) begin
                        state_d = PIPE_ONE;
                        main_we = 1'b1;
                        main_d  = skid_q;
                        skid_we = 1'b1;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                    main_we = 1'b1;
                    main_d  = BUBBLE_VAL;
                    skid_we = 1'b1;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State and payload registers; reset aborts everything like flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PIPE_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            if (main_we) main_q <= main_d;
            if (skid_we) skid_q <= skid_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: driver queues expected beats, monitor checks outputs.
module tb_pipe_stage_skid;

    localparam int unsigned PW    = 32;
    localparam int unsigned CW    = 4;
    localparam logic [PW-1:0] BUB = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
    logic [PW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] exp_q[$];

    pipe_stage_skid #(
        .PAYLOAD_W  (PW),
        .BUBBLE_VAL (BUB),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted output beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat got=%h required=none", out_data);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL out_beat got=%h required=%h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait (bounded) for acceptance, queue it as expected output.
    task automatic send(input logic [PW-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(d);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=no_accept required=accept data=%h", d);
        end
    endtask

    initial begin
        logic [PW-1:0] stream [3];
        stream[0] = 32'h11;
        stream[1] = 32'h22;
        stream[2] = 32'h33;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall_clr = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_occ",       32'(occupancy), 32'd0);
        check("rst_out_data",  out_data,       BUB);
        check("rst_stall",     32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stream_in_ready", 32'(in_ready), 32'd1);
            send(stream[i]);
            check("stream_occ",      32'(occupancy), 32'd1);
            check("stream_out_data", out_data,       stream[i]);
        end
        tick();
        check("stream_drained_occ", 32'(occupancy), 32'd0);

        // Back-pressure fills skid; third beat held upstream
        out_ready = 1'b0;
        send(32'hA1);
        check("bp_occ1", 32'(occupancy), 32'd1);
        send(32'hA2);
        in_valid = 1'b1;
        in_data  = 32'hA3;
        @(negedge clk);
        check("bp_occ2",      32'(occupancy), 32'd2);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_data",  out_data,       32'hA1);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        check("bp_stall_cnt", 32'(stall_cnt), 32'd4);
        send(32'hA3);
        tick();
        tick();
        check("bp_drained_occ", 32'(occupancy), 32'd0);
        check("bp_stall_hold",  32'(stall_cnt), 32'd4);

        // Flush while full drops held beats and the concurrent upstream beat
        out_ready = 1'b0;
        send(32'hB1);
        send(32'hB2);
        in_valid = 1'b1;
        in_data  = 32'hB3;
        flush    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("fl_out_valid_gated", 32'(out_valid), 32'd0);
        check("fl_out_data_gated",  out_data,       BUB);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ",       32'(occupancy), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_data",  out_data,       BUB);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_stall",     32'(stall_cnt), 32'd5);
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Stall counter saturation and clear priority
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("sat_cleared", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0;
        send(32'hD1);
        repeat (20) tick();
        check("sat_max", 32'(stall_cnt), 32'd15);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("sat_clr_prio", 32'(stall_cnt), 32'd0);
        tick();
        check("sat_restart", 32'(stall_cnt), 32'd1);

        // Reset mid-stream with both entries held
        send(32'hD2);
        check("mr_occ2", 32'(occupancy), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mr_occ",       32'(occupancy), 32'd0);
        check("mr_stall",     32'(stall_cnt), 32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        check("mr_out_data",  out_data,       BUB);
        out_ready = 1'b1;
        send(32'hC1);
        check("mr_c1_valid", 32'(out_valid), 32'd1);
        check("mr_c1_data",  out_data,       32'hC1);
        tick();
        tick();
        check("end_occ",     32'(occupancy),   32'd0);
        check("end_queue",   32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
